// File: rtl/mdu_hilo_ctrl.sv
`default_nettype none
// mdu_hilo_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Revision 1.0
module mdu_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic               is_div;
  logic               div_zero;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   orig_rs;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      iter;

  logic               launch;
  logic               commit;
  logic               op_signed;
  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;

  // The most negative value maps onto itself, which reads correctly as unsigned.
  assign op_signed = ~op[0];
  assign abs_rs    = (op_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign abs_rt    = (op_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

  // Shift-add step: acc = {partial product high, multiplier bits remaining}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient shift register}.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mthi | mtlo | hilo_rd);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush)                  state_next = IDLE;
        else if (iter == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        commit     = ~flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      orig_rs  <= '0;
      divisor  <= '0;
      acc      <= '0;
      iter     <= '0;
    end else begin
      done <= commit;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (launch) begin
            is_div   <= op[1];
            div_zero <= (rt_data == '0);
            neg_q    <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r    <= op_signed & rs_data[WIDTH-1];
            orig_rs  <= rs_data;
            divisor  <= abs_rt;
            acc      <= {{WIDTH{1'b0}}, abs_rs};
            iter     <= '0;
          end
        end
        RUN: begin
          acc  <= is_div ? div_next : mul_next;
          iter <= iter + 1'b1;
        end
        FIX: begin
          if (commit) begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= orig_rs;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo_ctrl.sv
`default_nettype none
// tb_mdu_hilo_ctrl: directed self-checking bench for the HI/LO multiply/divide controller.
// Revision 1.0
module tb_mdu_hilo_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset, start, mthi, mtlo, hilo_rd, flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data, rt_data, wdata;
  logic             busy, stall, done;
  logic [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu_hilo_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .hilo_rd(hilo_rd), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0; rs_data = 32'hDEADBEEF; rt_data = 32'h0BADF00D;
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int edges;
    launch(o, a, b);
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    wait_done(edges);
    check({tag, "_latency"}, 64'(edges), 64'(LAT));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bad, pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; hilo_rd = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negrt", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    // Hazard: EX reads HI/LO and writes LO mid-operation.
    launch(2'b00, 32'd3, 32'd4);
    tick(); tick(); tick(); tick();
    hilo_rd = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    #1;
    check("haz_stall_on", 64'(stall), 64'd1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!busy) break;
      if (!stall) bad++;
    end
    check("haz_stall_hold", 64'(bad), 64'd0);
    check("haz_busy_end", 64'(busy), 64'd0);
    check("haz_stall_off", 64'(stall), 64'd0);
    check("haz_lo_product", 64'(lo), 64'd12);
    tick();
    check("haz_lo_mtlo", 64'(lo), 64'h1234);
    hilo_rd = 1'b0; mtlo = 1'b0;

    // Flush mid-divide leaves HI/LO untouched and produces no done.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA;
    tick();
    mthi = 1'b0; wdata = 32'h5555;
    tick();
    mtlo = 1'b0;
    check("mt_hi", 64'(hi), 64'hAAAA);
    check("mt_lo", 64'(lo), 64'h5555);
    launch(2'b10, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'hAAAA);
    check("flush_lo", 64'(lo), 64'h5555);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'd0);
    check("flush_hi_late", 64'(hi), 64'hAAAA);

    // start is ignored when flush is asserted in IDLE.
    start = 1'b1; flush = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_blocks_start", 64'(busy), 64'd0);

    // Reset mid-divide.
    launch(2'b10, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- Iterative multiply/divide controller for the MIPS core, owning the HI/LO registers.
- Sequences one shared shift/add-subtract datapath for MULT, MULTU, DIV and DIVU, handles signed/unsigned operand conditioning, and services MTHI/MTLO writes.
- Raises a pipeline stall when the EX stage touches HI/LO while an operation is in flight.
- Sits beside the ALU in EX; results are read by MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch the operation selected by op; sampled only in IDLE
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- rs_data  in  WIDTH  multiplicand / dividend
- rt_data  in  WIDTH  multiplier / divisor
- mthi  in  1  write wdata into HI
- mtlo  in  1  write wdata into LO
- wdata  in  WIDTH  MTHI/MTLO data
- hilo_rd  in  1  MFHI/MFLO present in EX
- flush  in  1  exception flush; cancels an in-flight operation
- busy  out  1  operation in progress
- stall  out  1  hold pipeline
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: state=IDLE; hi=0, lo=0, busy=0, done=0, stall=0. Reset mid-operation aborts immediately; the partial result is discarded.
- State IDLE:
  - start=1 latches op, sign flags, |rs| and |rt|, then moves to RUN with iter=0.
  - Absolute values are taken only for signed ops. |0x80000000| is treated as unsigned 0x80000000.
- State RUN: one iteration per cycle for WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract (remainder/quotient pair).
  - At iter=WIDTH-1 go to FIX.
- State FIX (1 cycle), then IDLE:
  - Apply sign correction; write hi/lo; pulse done.
  - MULT: negate the 64-bit product if sign(rs)^sign(rt).
  - DIV: negate the quotient if sign(rs)^sign(rt); negate the remainder if sign(rs).
  - lo = product[WIDTH-1:0] or quotient; hi = product[2*WIDTH-1:WIDTH] or remainder.
- Latency: start sampled at edge N; hi/lo valid and busy=0 after edge N+WIDTH+1 (33 edges for WIDTH=32); done is high in the cycle following the FIX edge.
- busy = (state != IDLE); it rises on the edge that samples start.
- Divide by zero (rt=0, signed or unsigned): lo=all ones, hi=original rs_data. The FIX sign step is skipped.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the abs/negate path and is not an exception.
- stall = busy & (start | mthi | mtlo | hilo_rd). It is combinational, so EX holds until IDLE.
  - start, mthi and mtlo are ignored while busy; the pipeline re-presents them after the stall.
- MTHI/MTLO in IDLE: write on the same edge.
  - Simultaneous start+mthi/mtlo in IDLE: the write is applied and the operation launches; FIX later overwrites both registers.
- flush=1 while busy: return to IDLE next edge; hi/lo unchanged; done stays 0. flush in IDLE has no effect, and start is ignored in a cycle where flush=1.
- Simultaneous reset and flush: reset wins.
- Inputs rs_data/rt_data need only be valid in the start cycle; the operands are registered internally.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once, busy low.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Division boundary cases:
  - DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazard: start MULT, assert hilo_rd and mtlo at cycle 5 -> stall=1 until busy falls, mtlo ignored while busy; after re-presenting in IDLE, mtlo wdata=0x1234 -> lo=0x1234.
- Abort cases:
  - hi=0xAAAA, lo=0x5555, start DIV, flush at cycle 10 -> IDLE next edge, hi/lo unchanged, no done.
  - Repeat with reset at cycle 10 -> hi=lo=0, busy=0.
